key_progress_ctrl: RTL and testbench
====================================

Name: key_progress_ctrl

Overview:
- Game-logic stage directly upstream of the object renderer; produces the `key_find` progress code that the renderer uses to choose which key sprite to draw in STAGE1.
- Tracks the player hitbox against the active key's screen box.
- Requires a sustained grab (action held while overlapping) to collect a key, then advances progress NONE→FIND_KEY→FIND_LIGHT→FIND_DOOR.
- Flags stage clear to the top-level FSM once the third key is taken.

Parameters:
- HOLD_CYC, 12_500_000, consecutive cycles action+overlap must persist to collect a key (125 ms @100 MHz).
- CNT_W, 24, width of hold counter; must satisfy 2^CNT_W > HOLD_CYC.
- PW, 20, player hitbox edge length in pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- state  in  4  top-level game state (STAGE1 = 2).
- player_x  in  9  player hitbox left edge, 320-wide coordinate space.
- player_y  in  9  player hitbox top edge, 240-high coordinate space.
- act  in  1  grab button level, already synchronised/debounced.
- key_find  out  2  progress code: 0 NONE, 1 FIND_KEY, 2 FIND_LIGHT, 3 FIND_DOOR.
- charging  out  1  high while a grab is accumulating.
- pickup_pulse  out  1  one-cycle pulse on each key collected.
- stage_clear  out  1  one-cycle pulse when key_find goes 2→3.

Behaviour:
- Design style: one clock, `clk`. Reset is asynchronous and active-high on `rst`. On reset: key_find=0, charging=0, pickup_pulse=0, stage_clear=0, FSM=IDLE, counter=0.

Key boxes (20x20, half-open [lo, lo+20)), indexed by the current key_find:
- key_find=0: x 65..84, y 35..54.
- key_find=1: x 235..254, y 35..54.
- key_find=2: x 235..254, y 205..224.
- key_find=3: no target; overlap forced 0.

Overlap (combinational, 10-bit unsigned, no wrap):
- `ov = (px < kx+20) && (kx < px+PW) && (py < ky+20) && (ky < py+PW)`.

FSM (registered):
- IDLE: if state==STAGE1 && act && ov → CHARGING, counter=1.
- CHARGING: charging=1.
  - If !act or !ov → IDLE, counter=0.
  - Else if counter==HOLD_CYC-1 → collect, go to WAIT_RELEASE.
  - Else counter++.
- Collect (same edge):
  - key_find++.
  - pickup_pulse=1 for exactly one cycle.
  - stage_clear=1 for one cycle iff old key_find==2.
- WAIT_RELEASE: stays until act==0, then → IDLE. Holding act across the next key's box must not chain a second pickup.
- Latency:
  - Collection occurs on the edge where act+ov have been sampled high for HOLD_CYC consecutive cycles.
  - Outputs are visible the next cycle.

Boundaries:
- state != STAGE1 at any edge: synchronously key_find=0, FSM=IDLE, counter=0, charging=0; pulses forced 0.
- key_find==3: saturates; no further pickups; FSM never leaves IDLE in STAGE1.
- Player touching box edge exactly (px+PW == kx): no overlap.
- Player at px=0 or px=319: comparisons done in 10 bits; no false overlap.
- act drop of a single cycle during CHARGING: full restart, counter back to 0.
- rst asserted mid-charge: immediate clear; no pulse emitted.

Decomposition:
- Shared package/header holds:
  - state codes TITLE..FAIL (0..8);
  - progress codes NONE/FIND_KEY/FIND_LIGHT/FIND_DOOR;
  - key box constants KEY1_X=65, KEY1_Y=35, KEY2_X=235, KEY2_Y=35, KEY3_X=235, KEY3_Y=205, KEY_SZ=20.
- Both this block and the renderer consume these constants.
- One natural sub-module: `box_overlap` (combinational AABB test, parameterised sizes), reusable for door/light hit tests.

Test Plan (HOLD_CYC=4):
1. Reset then state=2, player (60,30), act=1 held 4 cycles → pickup_pulse on cycle 4, key_find=1; charging was 1 for cycles 1–4.
2. Continue holding act, move player to (230,30) → no second pickup while act high; release 1 cycle, hold 4 → key_find=2, one pickup pulse.
3. Player (230,200), hold 4 → key_find=3, pickup_pulse and stage_clear both high on the same single cycle; further holds → no change.
4. key_find=0, player (45,30) (px+20==65, edge touch), act held 10 cycles → no pickup; player (46,30) → pickup after 4.
5. Charging at count 3, act drops 1 cycle, then re-held → pickup only 4 cycles after re-assert; separately, state→3 mid-charge → key_find=0, charging=0, no pulse.
6. Async rst pulse between clock edges while key_find=2 → outputs zero immediately, before next clk edge.

Source files
------------

// File: rtl/key_progress_ctrl_pkg.sv
// Shared game constants: top-level state codes, key progress codes and key box placement.
// Consumed by the key progress controller and by the object renderer.
package key_progress_ctrl_pkg;

  typedef enum logic [3:0] {
    TITLE        = 4'd0,
    INTRO        = 4'd1,
    STAGE1       = 4'd2,
    STAGE1_CLEAR = 4'd3,
    STAGE2       = 4'd4,
    STAGE2_CLEAR = 4'd5,
    BOSS         = 4'd6,
    WIN          = 4'd7,
    FAIL         = 4'd8
  } game_state_t;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    FIND_KEY   = 2'd1,
    FIND_LIGHT = 2'd2,
    FIND_DOOR  = 2'd3
  } progress_t;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CHARGING     = 2'd1,
    WAIT_RELEASE = 2'd2
  } ctrl_state_t;

  localparam logic [9:0] KEY1_X = 10'd65;
  localparam logic [9:0] KEY1_Y = 10'd35;
  localparam logic [9:0] KEY2_X = 10'd235;
  localparam logic [9:0] KEY2_Y = 10'd35;
  localparam logic [9:0] KEY3_X = 10'd235;
  localparam logic [9:0] KEY3_Y = 10'd205;
  localparam int unsigned KEY_SZ = 20;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       valid;
  } key_box_t;

  // Once every key is held there is nothing left to grab, so the box is marked invalid.
  function automatic key_box_t key_box_for(input logic [1:0] kf);
    key_box_t b;
    b = '{x: 10'd0, y: 10'd0, valid: 1'b0};
    case (kf)
      2'd0:    b = '{x: KEY1_X, y: KEY1_Y, valid: 1'b1};
      2'd1:    b = '{x: KEY2_X, y: KEY2_Y, valid: 1'b1};
      2'd2:    b = '{x: KEY3_X, y: KEY3_Y, valid: 1'b1};
      default: b = '{x: 10'd0, y: 10'd0, valid: 1'b0};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/key_progress_ctrl_if.sv
// Bundle between the game FSM / player logic and the key progress controller.
interface key_progress_ctrl_if;
  logic [3:0] state;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic       act;
  logic [1:0] key_find;
  logic       charging;
  logic       pickup_pulse;
  logic       stage_clear;

  modport master (
    output state, player_x, player_y, act,
    input  key_find, charging, pickup_pulse, stage_clear
  );

  modport slave (
    input  state, player_x, player_y, act,
    output key_find, charging, pickup_pulse, stage_clear
  );
endinterface

// File: rtl/key_progress_ctrl_box_overlap.sv
// Combinational axis-aligned box intersection on half-open boxes in 10-bit space.
// Edges that merely touch do not count; 10 bits keep 9-bit coordinates plus size from wrapping.
module box_overlap #(
  parameter int unsigned A_W = 20,
  parameter int unsigned A_H = 20,
  parameter int unsigned B_W = 20,
  parameter int unsigned B_H = 20
) (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  output logic       ov
);
  localparam logic [9:0] AW = 10'(A_W);
  localparam logic [9:0] AH = 10'(A_H);
  localparam logic [9:0] BW = 10'(B_W);
  localparam logic [9:0] BH = 10'(B_H);

  assign ov = (ax < bx + BW) && (bx < ax + AW) &&
              (ay < by + BH) && (by < ay + AH);
endmodule

// File: rtl/key_progress_ctrl.sv
// Key collection controller: a sustained grab over the active key box advances key_find,
// pulsing pickup_pulse per key and stage_clear when the last key is taken.
module key_progress_ctrl
  import key_progress_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 12_500_000,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned PW       = 20
) (
  input logic              clk,
  input logic              rst,
  key_progress_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  ctrl_state_t      fsm;
  logic [CNT_W-1:0] count;
  logic [1:0]       key_find_q;
  logic             charging_q;
  logic             pickup_q;
  logic             clear_q;
  key_box_t         box;
  logic             ov_raw;
  logic             ov;

  assign box = key_box_for(key_find_q);

  box_overlap #(
    .A_W(PW),
    .A_H(PW),
    .B_W(KEY_SZ),
    .B_H(KEY_SZ)
  ) u_key_overlap (
    .ax({1'b0, bus.player_x}),
    .ay({1'b0, bus.player_y}),
    .bx(box.x),
    .by(box.y),
    .ov(ov_raw)
  );

  assign ov = ov_raw && box.valid;

  // Leaving STAGE1 wipes progress outright; otherwise the grab FSM runs with one-shot pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      count      <= '0;
      key_find_q <= 2'd0;
      charging_q <= 1'b0;
      pickup_q   <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      pickup_q <= 1'b0;
      clear_q  <= 1'b0;
      if (bus.state != STAGE1) begin
        fsm        <= IDLE;
        count      <= '0;
        key_find_q <= 2'd0;
        charging_q <= 1'b0;
      end else begin
        case (fsm)
          IDLE: begin
            if (bus.act && ov) begin
              fsm        <= CHARGING;
              count      <= CNT_W'(1);
              charging_q <= 1'b1;
            end
          end
          CHARGING: begin
            if (!bus.act || !ov) begin
              fsm        <= IDLE;
              count      <= '0;
              charging_q <= 1'b0;
            end else if (count == HOLD_LAST) begin
              fsm        <= WAIT_RELEASE;
              count      <= '0;
              charging_q <= 1'b0;
              key_find_q <= key_find_q + 2'd1;
              pickup_q   <= 1'b1;
              clear_q    <= (key_find_q == 2'd2);
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          // Holding the button over the next box must not chain another grab.
          WAIT_RELEASE: begin
            if (!bus.act) fsm <= IDLE;
          end
          default: begin
            fsm        <= IDLE;
            count      <= '0;
            charging_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.key_find     = key_find_q;
  assign bus.charging     = charging_q;
  assign bus.pickup_pulse = pickup_q;
  assign bus.stage_clear  = clear_q;
endmodule

// File: tb/tb_key_progress_ctrl.sv
// Self-checking bench for key_progress_ctrl with a short hold time; pickup events are
// predicted into a queue and popped by a monitor whenever the DUT pulses.
module tb_key_progress_ctrl;
  localparam int HOLD = 4;

  typedef struct {
    logic [1:0] kf;
    logic       clr;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  key_progress_ctrl_if bus();

  key_progress_ctrl #(
    .HOLD_CYC(HOLD),
    .CNT_W(8),
    .PW(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every pulse seen must match the oldest predicted pickup.
  always @(negedge clk) begin
    if (!rst && bus.pickup_pulse === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pickup: pickup_pulse=1 key_find=%0d, none predicted", bus.key_find);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.key_find !== e.kf || bus.stage_clear !== e.clr) begin
          failures++;
          $display("[TB] FAIL pickup_sb: got key_find=%0d stage_clear=%0b, want key_find=%0d stage_clear=%0b",
                   bus.key_find, bus.stage_clear, e.kf, e.clr);
        end
      end
    end else if (!rst && bus.stage_clear === 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL lone_stage_clear: stage_clear=1 without pickup_pulse");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pickup(input logic [1:0] kf, input logic clr);
    exp_t e;
    e.kf  = kf;
    e.clr = clr;
    sb.push_back(e);
  endtask

  // Release, move, then hold for the full grab time; the monitor verifies the pulse.
  task automatic collect_key(input int x, input int y, input logic [1:0] kf, input logic clr);
    bus.act = 1'b0;
    step();
    bus.player_x = 9'(x);
    bus.player_y = 9'(y);
    bus.act = 1'b1;
    for (int i = 0; i < HOLD - 1; i++) step();
    expect_pickup(kf, clr);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.state = 4'd0;
    bus.player_x = 9'd0;
    bus.player_y = 9'd0;
    bus.act = 1'b0;
    step();
    step();
    checks++;
    if (bus.key_find !== 2'd0 || bus.charging !== 1'b0 ||
        bus.pickup_pulse !== 1'b0 || bus.stage_clear !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got kf=%0d chg=%0b pk=%0b clr=%0b, want all 0",
               bus.key_find, bus.charging, bus.pickup_pulse, bus.stage_clear);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_key();
    bus.state = 4'd2;
    bus.player_x = 9'd60;
    bus.player_y = 9'd30;
    bus.act = 1'b1;
    for (int i = 1; i <= HOLD - 1; i++) begin
      step();
      checks++;
      if (bus.charging !== 1'b1 || bus.key_find !== 2'd0) begin
        failures++;
        $display("[TB] FAIL first_charge_c%0d: got chg=%0b kf=%0d, want chg=1 kf=0",
                 i, bus.charging, bus.key_find);
      end
    end
    expect_pickup(2'd1, 1'b0);
    step();
    checks++;
    if (bus.pickup_pulse !== 1'b1 || bus.key_find !== 2'd1 || bus.charging !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_pickup: got pk=%0b kf=%0d chg=%0b, want pk=1 kf=1 chg=0",
               bus.pickup_pulse, bus.key_find, bus.charging);
    end
    step();
    checks++;
    if (bus.pickup_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pulse_width: got pk=%0b, want 0", bus.pickup_pulse);
    end
  endtask

  task automatic test_no_chain();
    bus.player_x = 9'd230;
    bus.player_y = 9'd30;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.key_find !== 2'd1 || bus.charging !== 1'b0) begin
      failures++;
      $display("[TB] FAIL no_chain: got kf=%0d chg=%0b, want kf=1 chg=0", bus.key_find, bus.charging);
    end
    collect_key(230, 30, 2'd2, 1'b0);
    checks++;
    if (bus.key_find !== 2'd2 || bus.pickup_pulse !== 1'b1) begin
      failures++;
      $display("[TB] FAIL second_key: got kf=%0d pk=%0b, want kf=2 pk=1", bus.key_find, bus.pickup_pulse);
    end
  endtask

  task automatic test_stage_clear();
    collect_key(230, 200, 2'd3, 1'b1);
    checks++;
    if (bus.key_find !== 2'd3 || bus.pickup_pulse !== 1'b1 || bus.stage_clear !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stage_clear: got kf=%0d pk=%0b clr=%0b, want kf=3 pk=1 clr=1",
               bus.key_find, bus.pickup_pulse, bus.stage_clear);
    end
    step();
    checks++;
    if (bus.stage_clear !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_width: got clr=%0b, want 0", bus.stage_clear);
    end
    bus.act = 1'b0;
    step();
    bus.act = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus.key_find !== 2'd3 || bus.charging !== 1'b0) begin
      failures++;
      $display("[TB] FAIL saturate: got kf=%0d chg=%0b, want kf=3 chg=0", bus.key_find, bus.charging);
    end
  endtask

  task automatic test_edge_touch();
    bus.act = 1'b0;
    bus.state = 4'd3;
    step();
    checks++;
    if (bus.key_find !== 2'd0) begin
      failures++;
      $display("[TB] FAIL leave_stage: got kf=%0d, want 0", bus.key_find);
    end
    bus.state = 4'd2;
    bus.player_x = 9'd45;
    bus.player_y = 9'd30;
    bus.act = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (bus.key_find !== 2'd0 || bus.charging !== 1'b0) begin
      failures++;
      $display("[TB] FAIL edge_touch: got kf=%0d chg=%0b, want kf=0 chg=0", bus.key_find, bus.charging);
    end
    collect_key(46, 30, 2'd1, 1'b0);
    checks++;
    if (bus.key_find !== 2'd1) begin
      failures++;
      $display("[TB] FAIL one_px_overlap: got kf=%0d, want 1", bus.key_find);
    end
    bus.act = 1'b0;
    step();
    bus.player_x = 9'd319;
    bus.act = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (bus.key_find !== 2'd1 || bus.charging !== 1'b0) begin
      failures++;
      $display("[TB] FAIL far_right: got kf=%0d chg=%0b, want kf=1 chg=0", bus.key_find, bus.charging);
    end
  endtask

  task automatic test_act_drop();
    bus.act = 1'b0;
    step();
    bus.player_x = 9'd230;
    bus.act = 1'b1;
    for (int i = 0; i < HOLD - 1; i++) step();
    bus.act = 1'b0;
    step();
    checks++;
    if (bus.charging !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_restart: got chg=%0b, want 0", bus.charging);
    end
    bus.act = 1'b1;
    for (int i = 0; i < HOLD - 1; i++) step();
    checks++;
    if (bus.key_find !== 2'd1 || bus.charging !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_recharge: got kf=%0d chg=%0b, want kf=1 chg=1", bus.key_find, bus.charging);
    end
    expect_pickup(2'd2, 1'b0);
    step();
    checks++;
    if (bus.key_find !== 2'd2) begin
      failures++;
      $display("[TB] FAIL drop_pickup: got kf=%0d, want 2", bus.key_find);
    end
    bus.act = 1'b0;
    step();
    bus.player_y = 9'd200;
    bus.act = 1'b1;
    step();
    step();
    bus.state = 4'd3;
    step();
    checks++;
    if (bus.key_find !== 2'd0 || bus.charging !== 1'b0 || bus.pickup_pulse !== 1'b0) begin
      failures++;
      $display("[TB] FAIL state_exit: got kf=%0d chg=%0b pk=%0b, want 0 0 0",
               bus.key_find, bus.charging, bus.pickup_pulse);
    end
  endtask

  task automatic test_async_reset();
    bus.act = 1'b0;
    bus.state = 4'd2;
    collect_key(60, 30, 2'd1, 1'b0);
    collect_key(230, 30, 2'd2, 1'b0);
    bus.act = 1'b0;
    step();
    bus.player_y = 9'd200;
    bus.act = 1'b1;
    step();
    step();
    checks++;
    if (bus.key_find !== 2'd2 || bus.charging !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset: got kf=%0d chg=%0b, want kf=2 chg=1", bus.key_find, bus.charging);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.key_find !== 2'd0 || bus.charging !== 1'b0 ||
        bus.pickup_pulse !== 1'b0 || bus.stage_clear !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: got kf=%0d chg=%0b pk=%0b clr=%0b, want all 0",
               bus.key_find, bus.charging, bus.pickup_pulse, bus.stage_clear);
    end
    step();
    bus.act = 1'b0;
    rst = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_first_key();
    test_no_chain();
    test_stage_clear();
    test_edge_touch();
    test_act_drop();
    test_async_reset();
    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drain: %0d predicted pickups never seen, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
